// File: rtl/adel_imem.sv
// adel_imem -- instruction memory and program loader for the adel core.
//
// A program arrives as a byte stream (high byte of each word first) on a
// valid/ready load port. Bytes are paired into 16-bit words and written to
// a flop array. The core fetches from that array combinationally through
// pc/inst. While a load is in progress, the core is held in reset through
// core_nrst.
//
// Ports:
//   clk        : clock
//   nrst       : asynchronous active-low reset; clears memory and loader state
//   pc         : fetch address from the core (word address)
//   inst       : instruction at pc (combinational); 0 when pc >= DEPTH
//   core_nrst  : registered active-low reset to the core, low while loading
//   ld_start   : one-cycle pulse that starts or restarts a load
//   ld_valid   : ld_byte carries a valid byte
//   ld_byte    : load data byte
//   ld_ready   : loader accepts a byte this cycle (high while loading)
//   ld_end     : one-cycle pulse that terminates the load
//   ld_count   : words written by the current or most recent load
//   ld_busy    : high while loading
module adel_imem #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic [15:0]   pc,
   output logic [15:0]   inst,
   output logic          core_nrst,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [7:0]    ld_byte,
   output logic          ld_ready,
   input  logic          ld_end,
   output logic [AW:0]   ld_count,
   output logic          ld_busy
);

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t        state_reg;
   logic          phase_lo_reg;   // 0: next byte is the high byte, 1: low byte
   logic [7:0]    hi_reg;         // high byte waiting for its partner
   logic [AW-1:0] waddr_reg;
   logic [AW:0]   count_reg;
   logic          core_nrst_reg;

   logic          wr_en;
   logic          last_write;
   logic [15:0]   mem_word [DEPTH];

   // A word is written on an accepted low byte. A restart in the same cycle
   // wins and the byte is dropped.
   assign wr_en      = (state_reg == LOAD) && !ld_start && ld_valid && phase_lo_reg;
   assign last_write = wr_en && (waddr_reg == AW'(DEPTH - 1));

   // Loader control. core_nrst is assigned alongside every state change so
   // it always reflects the state being entered.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg     <= RUN;
         phase_lo_reg  <= 1'b0;
         hi_reg        <= 8'h00;
         waddr_reg     <= '0;
         count_reg     <= '0;
         core_nrst_reg <= 1'b0;
      end else begin
         case (state_reg)
            RUN: begin
               if (ld_start) begin
                  state_reg     <= LOAD;
                  waddr_reg     <= '0;
                  count_reg     <= '0;
                  phase_lo_reg  <= 1'b0;
                  core_nrst_reg <= 1'b0;
               end else begin
                  core_nrst_reg <= 1'b1;
               end
            end
            LOAD: begin
               if (ld_start) begin
                  waddr_reg     <= '0;
                  count_reg     <= '0;
                  phase_lo_reg  <= 1'b0;
                  core_nrst_reg <= 1'b0;
               end else begin
                  if (ld_valid) begin
                     if (!phase_lo_reg) begin
                        hi_reg       <= ld_byte;
                        phase_lo_reg <= 1'b1;
                     end else begin
                        waddr_reg    <= waddr_reg + 1'b1;
                        count_reg    <= count_reg + 1'b1;
                        phase_lo_reg <= 1'b0;
                     end
                  end
                  // Exit after the byte is processed; a dangling high byte
                  // is simply forgotten by returning the phase to HI.
                  if (ld_end || last_write) begin
                     state_reg     <= RUN;
                     phase_lo_reg  <= 1'b0;
                     core_nrst_reg <= 1'b1;
                  end else begin
                     core_nrst_reg <= 1'b0;
                  end
               end
            end
            default: begin
               state_reg     <= RUN;
               core_nrst_reg <= 1'b0;
            end
         endcase
      end
   end

   // Memory words as individual flops so the whole array clears on reset.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [15:0] word_reg;
         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               word_reg <= 16'h0000;
            end else if (wr_en && (waddr_reg == AW'(gi))) begin
               word_reg <= {hi_reg, ld_byte};
            end
         end
         assign mem_word[gi] = word_reg;
      end
   endgenerate

   // Fetch reads the current flop contents, so a same-cycle write is seen
   // only from the next cycle.
   assign inst      = (pc < 16'(DEPTH)) ? mem_word[pc[AW-1:0]] : 16'h0000;

   assign core_nrst = core_nrst_reg;
   assign ld_ready  = (state_reg == LOAD);
   assign ld_busy   = (state_reg == LOAD);
   assign ld_count  = count_reg;

endmodule
